// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO PHY responder: frame states,
// opcode values, fixed register indices and frame field widths.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_PRE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_WDATA,
    S_RDATA
  } mdio_state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [4:0] REG_CTRL = 5'd0;
  localparam logic [4:0] REG_STAT = 5'd1;
  localparam logic [4:0] REG_ID1  = 5'd2;
  localparam logic [4:0] REG_ID2  = 5'd3;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned PHYAD_W = 5;
  localparam int unsigned REGAD_W = 5;
  localparam int unsigned TA_W    = 2;
  localparam int unsigned DATA_W  = 16;

  // Registers 1..3 are fixed identity/status words and ignore writes.
  function automatic logic is_const_reg(input logic [4:0] addr);
    return (addr == REG_STAT) || (addr == REG_ID1) || (addr == REG_ID2);
  endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// Brings mdc and md_in into the clk domain and flags each mdc rising edge,
// presenting the synchronized md_in value in the same clk as the edge pulse.
module mdio_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic mdc,
  input  logic md_in,
  output logic bit_edge,
  output logic md_bit
);

  logic mdc_meta, mdc_sync, mdc_last;
  logic md_meta, md_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdc_meta <= 1'b0;
      mdc_sync <= 1'b0;
      mdc_last <= 1'b0;
      md_meta  <= 1'b0;
      md_sync  <= 1'b0;
    end else begin
      mdc_meta <= mdc;
      mdc_sync <= mdc_meta;
      mdc_last <= mdc_sync;
      md_meta  <= md_in;
      md_sync  <= md_meta;
    end
  end

  assign bit_edge = mdc_sync & ~mdc_last;
  assign md_bit   = md_sync;

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO target: decodes MAC frames on mdc/md, serves a 32x16
// register file (regs 1..3 constant) and drives read data back on the pad.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int          PREAMBLE_LEN = 32,
  parameter logic [15:0] REG0_DEFAULT = 16'h3100,
  parameter logic [15:0] REG1_VALUE   = 16'h786D,
  parameter logic [15:0] PHY_ID1      = 16'h0022,
  parameter logic [15:0] PHY_ID2      = 16'h1619
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mdc,
  input  logic        md_in,
  output logic        md_out,
  output logic        md_oe,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_valid
);

  localparam int unsigned CNT_W = $clog2(PREAMBLE_LEN + 1);
  localparam logic [CNT_W-1:0] PRE_FULL = CNT_W'(PREAMBLE_LEN);

  logic bit_edge, md_bit;

  mdio_edge_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .mdc      (mdc),
    .md_in    (md_in),
    .bit_edge (bit_edge),
    .md_bit   (md_bit)
  );

  mdio_state_e          state;
  logic [CNT_W-1:0]     pre_cnt;
  logic [3:0]           bit_cnt;
  logic                 op_hi;
  logic                 is_read;
  logic                 match;
  logic [PHYAD_W-1:0]   phyad;
  logic [REGAD_W-1:0]   regad;
  logic [DATA_W-1:0]    shreg;
  logic [DATA_W-1:0]    regs [32];

  logic [REGAD_W-1:0]   regad_next;
  logic [DATA_W-1:0]    rd_word;
  logic [DATA_W-1:0]    wr_word;

  assign regad_next = {regad[REGAD_W-2:0], md_bit};
  assign wr_word    = {shreg[DATA_W-2:0], md_bit};

  // Read word is captured on the last REGAD bit, so decode the incoming address.
  always_comb begin
    rd_word = regs[regad_next];
    case (regad_next)
      REG_CTRL: rd_word = {1'b0, regs[REG_CTRL][DATA_W-2:0]};
      REG_STAT: rd_word = REG1_VALUE;
      REG_ID1:  rd_word = PHY_ID1;
      REG_ID2:  rd_word = PHY_ID2;
      default:  rd_word = regs[regad_next];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_PRE;
      pre_cnt  <= '0;
      bit_cnt  <= '0;
      op_hi    <= 1'b0;
      is_read  <= 1'b0;
      match    <= 1'b0;
      phyad    <= '0;
      regad    <= '0;
      shreg    <= '0;
      md_out   <= 1'b0;
      md_oe    <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_valid <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      regs[REG_CTRL] <= REG0_DEFAULT;
    end else begin
      wr_valid <= 1'b0;
      rd_valid <= 1'b0;
      if (bit_edge) begin
        case (state)
          S_PRE: begin
            if (md_bit) begin
              if (pre_cnt != PRE_FULL) pre_cnt <= pre_cnt + 1'b1;
            end else begin
              if (pre_cnt == PRE_FULL) state <= S_ST;
              pre_cnt <= '0;
            end
          end
          S_ST: begin
            bit_cnt <= '0;
            state   <= md_bit ? S_OP : S_PRE;
          end
          S_OP: begin
            op_hi <= md_bit;
            if (bit_cnt == 4'd1) begin
              bit_cnt <= '0;
              case ({op_hi, md_bit})
                OP_READ:  begin is_read <= 1'b1; state <= S_PHYAD; end
                OP_WRITE: begin is_read <= 1'b0; state <= S_PHYAD; end
                default:  state <= S_PRE;
              endcase
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_PHYAD: begin
            phyad <= {phyad[PHYAD_W-2:0], md_bit};
            if (bit_cnt == 4'(PHYAD_W - 1)) begin
              bit_cnt <= '0;
              state   <= S_REGAD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_REGAD: begin
            regad <= regad_next;
            if (bit_cnt == 4'(REGAD_W - 1)) begin
              bit_cnt <= '0;
              match   <= (phyad == PHY_ADDR);
              shreg   <= rd_word;
              state   <= S_TA;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_TA: begin
            if (bit_cnt == 4'd0) begin
              bit_cnt <= 4'd1;
              if (match && is_read) begin
                md_oe  <= 1'b1;
                md_out <= 1'b0;
              end else if (match && !md_bit) begin
                state <= S_PRE;
              end
            end else begin
              bit_cnt <= '0;
              if (match && is_read) begin
                md_out <= shreg[DATA_W-1];
                shreg  <= {shreg[DATA_W-2:0], 1'b0};
                state  <= S_RDATA;
              end else if (match && md_bit) begin
                state <= S_PRE;
              end else begin
                state <= S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (bit_cnt == 4'(DATA_W - 1)) begin
              md_oe    <= 1'b0;
              md_out   <= 1'b0;
              rd_valid <= 1'b1;
              bit_cnt  <= '0;
              state    <= S_PRE;
            end else begin
              md_out  <= shreg[DATA_W-1];
              shreg   <= {shreg[DATA_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_WDATA: begin
            shreg <= wr_word;
            if (bit_cnt == 4'(DATA_W - 1)) begin
              bit_cnt <= '0;
              state   <= S_PRE;
              // Mismatched frames of either opcode end here without side effects.
              if (match) begin
                wr_valid <= 1'b1;
                wr_addr  <= regad;
                wr_data  <= wr_word;
                if (regad == REG_CTRL) begin
                  if (wr_word[DATA_W-1]) begin
                    regs[REG_CTRL] <= REG0_DEFAULT;
                    for (int unsigned i = 4; i < 32; i++) regs[i] <= '0;
                  end else begin
                    regs[REG_CTRL] <= wr_word;
                  end
                end else if (!is_const_reg(regad)) begin
                  regs[regad] <= wr_word;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= S_PRE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: bit-bangs MDIO master frames on mdc/md
// and checks pad activity, read data and commit pulses against fixed values.
module tb_mdio_phy_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mdc;
  logic        md_in;
  logic        md_out;
  logic        md_oe;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_valid;

  int n_chk = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int oe_clks = 0;

  mdio_phy_responder #(
    .PHY_ADDR     (5'd1),
    .PREAMBLE_LEN (32),
    .REG0_DEFAULT (16'h3100),
    .REG1_VALUE   (16'h786D),
    .PHY_ID1      (16'h0022),
    .PHY_ID2      (16'h1619)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mdc      (mdc),
    .md_in    (md_in),
    .md_out   (md_out),
    .md_oe    (md_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_valid) rd_cnt++;
    if (wr_valid) wr_cnt++;
    if (md_oe) oe_clks++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    md_in = b;
    #40 mdc = 1'b1;
    #40 mdc = 1'b0;
  endtask

  // Sample j is taken just before rising edge E+j, where E carries REGAD bit 0.
  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd, input int abort_at,
                           output logic [15:0] rd, output logic [19:0] oe_vec,
                           output logic ta2);
    logic [13:0] hdr;
    logic [19:0] out_vec;
    logic        b;
    hdr = {2'b01, op, pa, ra};
    rd = '0;
    for (int i = 0; i < pre; i++) send_bit(1'b1);
    for (int i = 13; i >= 1; i--) send_bit(hdr[i]);
    for (int j = 0; j <= 19; j++) begin
      if (j == 0)       b = hdr[0];
      else if (j <= 2)  b = (op == 2'b01) ? (j == 1) : 1'b1;
      else if (j <= 18) b = (op == 2'b01) ? wd[18-j] : 1'b1;
      else              b = 1'b0;
      md_in = b;
      #40;
      oe_vec[j]  = md_oe;
      out_vec[j] = md_out;
      if (j == abort_at) begin
        chk("abort_oe_before", {31'd0, md_oe}, 32'd1);
        reset_n = 1'b0;
        #2;
        chk("abort_oe_async", {31'd0, md_oe}, 32'd0);
        chk("abort_out_async", {31'd0, md_out}, 32'd0);
        chk("abort_wr_addr", {27'd0, wr_addr}, 32'd0);
        #28 reset_n = 1'b1;
        #20;
        ta2 = 1'b0;
        return;
      end
      mdc = 1'b1;
      #40 mdc = 1'b0;
    end
    for (int j = 3; j <= 18; j++) rd[18-j] = out_vec[j];
    ta2 = out_vec[2];
  endtask

  task automatic do_read(input string tag, input logic [4:0] ra, input logic [15:0] exp);
    logic [15:0] rd;
    logic [19:0] oe_vec;
    logic        ta2;
    int rd0, oe0;
    rd0 = rd_cnt;
    oe0 = oe_clks;
    run_frame(32, 2'b10, 5'd1, ra, 16'h0000, -1, rd, oe_vec, ta2);
    chk({tag, "_data"}, {16'd0, rd}, {16'd0, exp});
    chk({tag, "_oe_pattern"}, {12'd0, oe_vec}, 32'h0007_FFFC);
    chk({tag, "_ta2_zero"}, {31'd0, ta2}, 32'd0);
    chk({tag, "_rd_valid"}, rd_cnt - rd0, 32'd1);
    chk({tag, "_oe_clks"}, oe_clks - oe0, 32'd136);
  endtask

  task automatic do_write(input string tag, input int pre, input logic [4:0] ra,
                          input logic [15:0] wd, input logic expect_commit);
    logic [15:0] rd;
    logic [19:0] oe_vec;
    logic        ta2;
    int wr0, oe0;
    wr0 = wr_cnt;
    oe0 = oe_clks;
    run_frame(pre, 2'b01, 5'd1, ra, wd, -1, rd, oe_vec, ta2);
    chk({tag, "_wr_valid"}, wr_cnt - wr0, expect_commit ? 32'd1 : 32'd0);
    chk({tag, "_oe_clks"}, oe_clks - oe0, 32'd0);
    if (expect_commit) begin
      chk({tag, "_wr_addr"}, {27'd0, wr_addr}, {27'd0, ra});
      chk({tag, "_wr_data"}, {16'd0, wr_data}, {16'd0, wd});
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic [19:0] oe_vec;
    logic        ta2;
    int rd0, oe0;

    mdc = 1'b0;
    md_in = 1'b1;
    reset_n = 1'b0;
    #30;
    chk("rst_md_oe", {31'd0, md_oe}, 32'd0);
    chk("rst_md_out", {31'd0, md_out}, 32'd0);
    chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
    reset_n = 1'b1;
    #20;

    do_read("read_id1", 5'd2, 16'h0022);

    do_write("wr_r5", 32, 5'd5, 16'hA5C3, 1'b1);
    do_read("rd_r5", 5'd5, 16'hA5C3);

    rd0 = rd_cnt;
    oe0 = oe_clks;
    run_frame(32, 2'b10, 5'd7, 5'd0, 16'h0000, -1, rd, oe_vec, ta2);
    chk("wrong_phy_oe_clks", oe_clks - oe0, 32'd0);
    chk("wrong_phy_rd_valid", rd_cnt - rd0, 32'd0);
    do_read("after_wrong_phy", 5'd3, 16'h1619);

    do_write("short_pre", 31, 5'd6, 16'hBEEF, 1'b0);
    do_read("rd_r6_after_short", 5'd6, 16'h0000);

    do_write("wr_r5_1234", 32, 5'd5, 16'h1234, 1'b1);
    do_write("soft_reset", 32, 5'd0, 16'h8000, 1'b1);
    do_read("rd_r0_default", 5'd0, 16'h3100);
    do_read("rd_r5_cleared", 5'd5, 16'h0000);
    do_write("wr_r1", 32, 5'd1, 16'hFFFF, 1'b1);
    do_read("rd_r1_const", 5'd1, 16'h786D);

    do_write("wr_r0_plain", 32, 5'd0, 16'h1140, 1'b1);
    do_read("rd_r0_plain", 5'd0, 16'h1140);

    run_frame(32, 2'b10, 5'd1, 5'd0, 16'h0000, 11, rd, oe_vec, ta2);
    do_read("rd_r0_after_rst", 5'd0, 16'h3100);
    do_read("rd_id2_after_rst", 5'd3, 16'h1619);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- PHY-side Clause-22 MDIO responder: the target end of the management interface that the Ethernet MAC drives as MDIO master (mdc/md pads).
- Holds a 32x16 PHY register file and answers MDIO read and write frames addressed to its PHY address.
- Used as a PHY stand-in for FPGA loopback builds and as the management bus model in system simulation.

Parameters:
- PHY_ADDR, 5'd1, PHY address this responder answers to.
- PREAMBLE_LEN, 32, consecutive 1 bits required before a start-of-frame is accepted (range 1..32).
- REG0_DEFAULT, 16'h3100, reset value of reg 0 (control).
- REG1_VALUE, 16'h786D, constant value of reg 1 (status); read-only.
- PHY_ID1, 16'h0022, constant value of reg 2; read-only.
- PHY_ID2, 16'h1619, constant value of reg 3; read-only.

Ports:
- clk  in  1  system clock; must run at 4x mdc frequency or faster.
- reset_n  in  1  asynchronous, active-low reset.
- mdc  in  1  management clock from the MAC (asynchronous to clk).
- md_in  in  1  MDIO pad input.
- md_out  out  1  MDIO pad output data.
- md_oe  out  1  MDIO pad output enable (1 = drive).
- wr_valid  out  1  one-clk pulse when a write frame commits.
- wr_addr  out  5  register address of the committed write.
- wr_data  out  16  data of the committed write.
- rd_valid  out  1  one-clk pulse when a read frame to this PHY completes.

Behaviour:
- Reset (asynchronous on reset_n low, mid-frame included):
  - md_oe=0, md_out=0, wr_valid=0, rd_valid=0, wr_addr=0, wr_data=0.
  - FSM=PRE, preamble count=0.
  - reg0=REG0_DEFAULT; regs 4..31=0.
- Input sampling:
  - mdc and md_in each pass through a 2-flop synchronizer.
  - A "bit edge" is a detected mdc 0->1 transition; md_in is sampled on the synchronized value in that same clk.
  - All FSM progress happens only on bit edges; if mdc stops, all state holds.
- FSM states: PRE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA.
  - PRE: count consecutive sampled 1s, saturating at PREAMBLE_LEN; a 0 with count<PREAMBLE_LEN clears the count. A 0 with count==PREAMBLE_LEN is ST bit 1 -> ST.
  - ST: expects 1; otherwise -> PRE (count=0).
  - OP: 2 bits. 10=read, 01=write; 00 or 11 -> PRE.
  - PHYAD, then REGAD: 5 bits each, MSB first.
  - After REGAD bit 0 (edge E), go to TA. A PHYAD mismatch still walks the full frame length (TA + 16 data) with md_oe=0 and no write, then -> PRE.
- Read (address match):
  - Edge E: md_oe stays 0 (TA bit 1 = Z). Data word is latched here (reg value, or the constant for regs 1-3).
  - One clk after edge E+1: md_oe=1, md_out=0.
  - One clk after edge E+2+k (k=0..15): md_out=data[15-k].
  - One clk after edge E+18: md_oe=0, rd_valid pulses, FSM -> PRE.
- Write (address match):
  - TA bits sampled at E+1, E+2 must be 1,0; otherwise abort -> PRE with no write.
  - 16 data bits sampled MSB first at E+3..E+18.
  - At E+18: commit, wr_valid pulses one clk, wr_addr/wr_data hold until the next commit.
  - Writes to regs 1-3 pulse wr_valid but do not change stored values.
  - Reg 0 bit 15 is self-clearing: a write with bit15=1 reloads reg0=REG0_DEFAULT and regs 4..31=0. Reg 0 reads back with bit15=0.
- md_oe is never 1 outside RDATA/TA-bit-2 of a matching read.
- Latency: output change occurs 3 clk after the mdc rising edge at the pad (2 sync + 1 register).
- After a completed or aborted frame, a new frame needs a fresh preamble; the count restarts at 0.

Decomposition:
- Package mdio_pkg:
  - state enum.
  - OP_READ=2'b10, OP_WRITE=2'b01.
  - register indices REG_CTRL=0, REG_STAT=1, REG_ID1=2, REG_ID2=3.
  - frame field widths.
- Sub-module mdio_edge_sync: 2-flop synchronizers for mdc and md_in, plus rising-edge detect pulse.

Test Plan:
- Read ID: 32x1 preamble, ST=01, OP=10, PHYAD=1, REGAD=2 -> md_oe low during TA1, 0 on TA2, serial 16'h0022 MSB first, md_oe low after, rd_valid=1 once.
- Write then read: write reg 5 = 16'hA5C3 -> wr_valid pulse with wr_addr=5, wr_data=16'hA5C3; subsequent read of reg 5 returns 16'hA5C3.
- Wrong PHY address (PHYAD=7, read reg 0) -> md_oe stays 0 entire frame; a following frame to PHYAD=1 is answered normally.
- Short preamble (31 ones then 01) -> frame ignored, md_oe=0, no wr_valid; the next frame with a full preamble succeeds.
- Soft reset: write reg5=16'h1234, then write reg0=16'h8000 -> read reg0=16'h3100, read reg5=16'h0000; write reg1=16'hFFFF -> read reg1=16'h786D.
- Async reset asserted during RDATA bit 8 -> md_oe=0 immediately, reg0=REG0_DEFAULT; after release, a fresh full read frame completes correctly.
